fifo_word_packer: RTL and testbench

Downstream consumer of the synchronous FIFO. It pops narrow words from the FIFO read port and packs PACK consecutive words into one wide beat. Each beat is presented on a valid/ready output toward the wide-bus stage. A flush request emits a partial beat so that no data is stranded at end of frame.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_word_packer.sv | 128 ++++++++++++
 tb/tb_fifo_word_packer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO datapath constants and the word packer FSM state type.
package fifo_pkg;

   localparam int FIFO_WIDTH   = 16;
   localparam int FIFO_DEPTH   = 8;
   localparam int PACK_DEFAULT = 4;

   typedef enum logic [0:0] {
      S_FILL  = 1'b0,
      S_FLUSH = 1'b1
   } packer_state_e;

endpackage

// File: rtl/fifo_word_packer.sv
// Packs PACK FIFO words into one wide beat; a flush emits the partial beat. First beat valid PACK+1 cycles after the first read.
// Backpressure: one beat held in the output register plus a full accumulator, then FIFO reads stop until the output frees.
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int IN_WIDTH  = FIFO_WIDTH,
   parameter int PACK      = PACK_DEFAULT,
   parameter int OUT_WIDTH = IN_WIDTH * PACK,
   parameter int CW        = $clog2(PACK + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 fifo_empty,
   input  logic [IN_WIDTH-1:0]  fifo_data,
   output logic                 fifo_rd_en,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic [CW-1:0]        out_words,
   output logic                 busy
);

   localparam logic [CW-1:0] PACK_C    = CW'(PACK);
   localparam logic [CW-1:0] PACK_M1_C = CW'(PACK - 1);
   localparam logic [CW-1:0] ONE_C     = CW'(1);

   packer_state_e        state_q, state_d;
   logic [OUT_WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 pending_q, pending_d;
   logic                 out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic [CW-1:0]        out_words_q, out_words_d;

   logic                 out_free;
   logic                 load_out;
   logic                 room;
   logic                 rd_en;
   logic [OUT_WIDTH-1:0] acc_w;
   logic [CW-1:0]        cnt_n;
   logic                 fill_emit;
   logic                 flush_emit;

   // Read issue: keep at most PACK words committed (held + in flight),
   // except that the last lane may be refilled when its beat leaves this edge.
   always_comb begin
      out_free = !out_valid_q || out_ready;
      load_out = pending_q && (cnt_q == PACK_M1_C) && out_free;
      room     = ({1'b0, cnt_q} + {{CW{1'b0}}, pending_q}) < {1'b0, PACK_C};
      rd_en    = rst_n && !fifo_empty && (state_q == S_FILL) && (room || load_out);
   end

   // Accumulator view with this cycle's returning word already in place.
   always_comb begin
      acc_w = acc_q;
      cnt_n = cnt_q;
      if (pending_q) begin
         acc_w[cnt_q*IN_WIDTH +: IN_WIDTH] = fifo_data;
         cnt_n = cnt_q + ONE_C;
      end
   end

   always_comb begin
      fill_emit   = (cnt_n == PACK_C) && out_free;
      flush_emit  = (state_q == S_FLUSH) && (cnt_n != '0) && out_free;

      acc_d       = acc_w;
      cnt_d       = cnt_n;
      pending_d   = rd_en;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_words_d = out_words_q;

      // acc is cleared on every emit, so a partial beat has zeroed upper lanes.
      if (fill_emit || flush_emit) begin
         out_valid_d = 1'b1;
         out_data_d  = acc_w;
         out_words_d = cnt_n;
         acc_d       = '0;
         cnt_d       = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL: begin
            if (flush) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if ((cnt_n == '0) || out_free) begin
               state_d = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FILL;
         acc_q       <= '0;
         cnt_q       <= '0;
         pending_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_words_q <= '0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_words_q <= out_words_d;
      end
   end

   assign fifo_rd_en = rd_en;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_words  = out_words_q;
   assign busy       = (cnt_q != '0) || pending_q || (state_q == S_FLUSH);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: per-cycle vector table, corner sequences, random run against a word-queue model.
module tb_fifo_word_packer;

   localparam int W    = 16;
   localparam int PACK = 4;
   localparam int OW   = W * PACK;
   localparam int CW   = $clog2(PACK + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          fifo_empty;
   logic [W-1:0]  fifo_data = '0;
   logic          fifo_rd_en;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [OW-1:0] out_data;
   logic [CW-1:0] out_words;
   logic          busy;

   fifo_word_packer #(.IN_WIDTH(W), .PACK(PACK)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_words  (out_words),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // FIFO model: one-cycle read latency.
   logic [W-1:0] mem [1024];
   int wr_cnt = 0;
   int rd_cnt = 0;
   assign fifo_empty = (wr_cnt == rd_cnt);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_data <= mem[rd_cnt % 1024];
         rd_cnt    <= rd_cnt + 1;
      end
   end

   int total = 0;
   int bad   = 0;

   logic [W-1:0] push_q [$];
   logic         flush_nx = 1'b0;
   logic         rdy_nx   = 1'b0;

   logic          hold_vld = 1'b0;
   logic [OW-1:0] hold_data = '0;
   logic [CW-1:0] hold_words = '0;

   logic         sb_en = 1'b0;
   logic [W-1:0] exp_q [$];
   int           sb_beats = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      logic [OW-1:0] b;
      @(negedge clk);
      flush    = flush_nx;
      flush_nx = 1'b0;
      out_ready = rdy_nx;
      while (push_q.size() > 0) begin
         mem[wr_cnt % 1024] = push_q.pop_front();
         wr_cnt++;
      end
      #1;
      if (fifo_empty) chk("rd_en_while_empty", {63'b0, fifo_rd_en}, 64'd0);
      if (hold_vld && rst_n) begin
         chk("hold_valid", {63'b0, out_valid}, 64'd1);
         chk("hold_data", out_data, hold_data);
         chk("hold_words", 64'(out_words), 64'(hold_words));
      end
      hold_vld   = rst_n && out_valid && !out_ready;
      hold_data  = out_data;
      hold_words = out_words;
      if (sb_en && out_valid && out_ready) begin
         sb_beats++;
         if (exp_q.size() < PACK) begin
            chk("sb_unexpected_beat", 64'(exp_q.size()), 64'(PACK));
         end else begin
            b = '0;
            for (int j = 0; j < PACK; j++) b[j*W +: W] = exp_q.pop_front();
            chk("sb_beat_data", out_data, b);
            chk("sb_beat_words", 64'(out_words), 64'(PACK));
         end
      end
   endtask

   task automatic expect_beat(input string nm, input logic [63:0] d, input int w);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (out_valid) begin
            chk({nm, "_data"}, out_data, d);
            chk({nm, "_words"}, 64'(out_words), 64'(w));
            found = 1'b1;
            break;
         end
      end
      if (!found) chk({nm, "_timeout"}, 64'd0, 64'd1);
   endtask

   typedef struct {
      int          npush;
      logic        flush;
      logic        rdy;
      logic        exp_rd;
      logic        exp_vld;
      logic        exp_busy;
      int          exp_words;
      logic [63:0] exp_data;
   } vec_t;

   vec_t         tab [14];
   logic [W-1:0] seed_w [7];

   initial begin
      int widx;
      int nv;
      int pushed;
      int cyc;
      logic [63:0] cdata;
      int          cwords;

      seed_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA, 16'hBBBB, 16'hCCCC};
      // basic pack: reads c0..c3, beat visible in c5 only
      tab[0]  = '{4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 64'h0};
      tab[1]  = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 64'h0};
      tab[2]  = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 64'h0};
      tab[3]  = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 64'h0};
      tab[4]  = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h0};
      tab[5]  = '{0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 64'h4444_3333_2222_1111};
      tab[6]  = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 64'h0};
      // partial flush with the third word still in flight
      tab[7]  = '{3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 64'h0};
      tab[8]  = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 64'h0};
      tab[9]  = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 64'h0};
      tab[10] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h0};
      tab[11] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 64'h0};
      tab[12] = '{0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 64'h0000_CCCC_BBBB_AAAA};
      tab[13] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 64'h0};

      // reset with a non-empty FIFO
      rst_n = 1'b0;
      mem[0] = 16'hDEAD;
      wr_cnt = 1;
      tick();
      chk("rst_rd_en", {63'b0, fifo_rd_en}, 64'd0);
      chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_words", 64'(out_words), 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      wr_cnt = rd_cnt;
      tick();
      rst_n = 1'b1;
      rdy_nx = 1'b1;
      tick();

      widx = 0;
      for (int i = 0; i < 14; i++) begin
         for (int k = 0; k < tab[i].npush; k++) begin
            push_q.push_back(seed_w[widx]);
            widx++;
         end
         flush_nx = tab[i].flush;
         rdy_nx   = tab[i].rdy;
         tick();
         chk($sformatf("tab%0d_rd_en", i), {63'b0, fifo_rd_en}, {63'b0, tab[i].exp_rd});
         chk($sformatf("tab%0d_valid", i), {63'b0, out_valid}, {63'b0, tab[i].exp_vld});
         chk($sformatf("tab%0d_busy", i), {63'b0, busy}, {63'b0, tab[i].exp_busy});
         if (tab[i].exp_vld) begin
            chk($sformatf("tab%0d_data", i), out_data, tab[i].exp_data);
            chk($sformatf("tab%0d_words", i), 64'(out_words), 64'(tab[i].exp_words));
         end
      end

      // empty flush: flush state visible for one cycle, no beat
      flush_nx = 1'b1;
      nv = 0;
      tick();
      if (out_valid) nv++;
      tick();
      chk("eflush_busy_in_flush", {63'b0, busy}, 64'd1);
      if (out_valid) nv++;
      tick();
      chk("eflush_busy_back", {63'b0, busy}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (out_valid) nv++;
      end
      chk("eflush_no_beat", 64'(nv), 64'd0);

      // backpressure: 8 words, output stalled
      rdy_nx = 1'b0;
      for (int k = 1; k <= 8; k++) push_q.push_back(W'(16'h1000 + k));
      repeat (12) tick();
      chk("bp_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_data1", out_data, 64'h1004_1003_1002_1001);
      chk("bp_words", 64'(out_words), 64'd4);
      chk("bp_busy", {63'b0, busy}, 64'd1);
      push_q.push_back(16'h9999);
      tick();
      chk("bp_rd_stalled", {63'b0, fifo_rd_en}, 64'd0);
      rdy_nx = 1'b1;
      tick();
      chk("bp_acc1_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_acc1_data", out_data, 64'h1004_1003_1002_1001);
      tick();
      chk("bp_acc2_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_acc2_data", out_data, 64'h1008_1007_1006_1005);
      chk("bp_acc2_words", 64'(out_words), 64'd4);
      tick();
      flush_nx = 1'b1;
      expect_beat("bp_tail", 64'h0000_0000_0000_9999, 1);

      // flush on the same edge a full beat completes
      for (int k = 0; k < 4; k++) push_q.push_back(W'(16'h5000 + k));
      repeat (4) tick();
      flush_nx = 1'b1;
      nv = 0;
      cdata = '0;
      cwords = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (out_valid) begin
            nv++;
            cdata = out_data;
            cwords = int'(out_words);
         end
      end
      chk("coinc_beats", 64'(nv), 64'd1);
      chk("coinc_data", cdata, 64'h5003_5002_5001_5000);
      chk("coinc_words", 64'(cwords), 64'd4);
      chk("coinc_busy", {63'b0, busy}, 64'd0);

      // reset mid-operation
      push_q.push_back(16'h7777);
      push_q.push_back(16'h8888);
      repeat (4) tick();
      chk("rmid_busy_before", {63'b0, busy}, 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rmid_valid", {63'b0, out_valid}, 64'd0);
      chk("rmid_data", out_data, 64'd0);
      chk("rmid_words", 64'(out_words), 64'd0);
      chk("rmid_busy", {63'b0, busy}, 64'd0);
      chk("rmid_rd_en", {63'b0, fifo_rd_en}, 64'd0);
      hold_vld = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 4; k++) push_q.push_back(W'(k));
      expect_beat("rmid_clean", 64'h0004_0003_0002_0001, 4);
      repeat (2) tick();

      // random traffic against the word-queue model
      sb_en = 1'b1;
      sb_beats = 0;
      pushed = 0;
      cyc = 0;
      while (pushed < 120 && cyc < 3000) begin
         rdy_nx = ((cyc % 50) < 15) ? 1'b0 : ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            logic [W-1:0] wv;
            wv = W'($urandom);
            push_q.push_back(wv);
            exp_q.push_back(wv);
            pushed++;
         end
         tick();
         cyc++;
      end
      rdy_nx = 1'b1;
      for (int k = 0; k < 300 && exp_q.size() > 0; k++) tick();
      repeat (3) tick();
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_beats", 64'(sb_beats), 64'd30);
      chk("rand_idle", {63'b0, busy}, 64'd0);
      sb_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
